// File: rtl/id_exe_stage_reg_if.sv
// ID/EXE stage-register bundle: stall/flush/hazard controls, ID-side fields in, EXE-side fields out.
// The master (ID side) drives *_in and controls; the slave (stage register) drives *_out.
interface id_exe_stage_reg_if;
    logic        freeze;
    logic        flush;
    logic        hazard;

    logic [31:0] pc_in;
    logic [31:0] val_rn_in;
    logic [31:0] val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;
    logic [3:0]  src1_in;
    logic [3:0]  src2_in;
    logic [3:0]  exe_cmd_in;
    logic        imm_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic        wb_en_in;
    logic        b_in;
    logic        s_in;
    logic        status_c_in;

    logic [31:0] pc_out;
    logic [31:0] val_rn_out;
    logic [31:0] val_rm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out;
    logic [3:0]  src1_out;
    logic [3:0]  src2_out;
    logic [3:0]  exe_cmd_out;
    logic        imm_out;
    logic        mem_r_en_out;
    logic        mem_w_en_out;
    logic        wb_en_out;
    logic        b_out;
    logic        s_out;
    logic        status_c_out;
    logic        valid_out;
    logic [15:0] bubble_count;

    modport master (
        output freeze, flush, hazard,
        output pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
        output dest_in, src1_in, src2_in, exe_cmd_in,
        output imm_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, status_c_in,
        input  pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out,
        input  dest_out, src1_out, src2_out, exe_cmd_out,
        input  imm_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, status_c_out,
        input  valid_out, bubble_count
    );

    modport slave (
        input  freeze, flush, hazard,
        input  pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
        input  dest_in, src1_in, src2_in, exe_cmd_in,
        input  imm_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, status_c_in,
        output pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out,
        output dest_out, src1_out, src2_out, exe_cmd_out,
        output imm_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, status_c_out,
        output valid_out, bubble_count
    );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze hold, flush/hazard bubbles and a saturating bubble counter.
// Define FORWARDING_EN to register src1/src2 for the forwarding unit; otherwise they read 0.
module id_exe_stage_reg (
    input  logic                clk,
    input  logic                rst,
    id_exe_stage_reg_if.slave   bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  exe_cmd;
        logic        imm;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        b;
        logic        s;
        logic        status_c;
    } payload_t;

    payload_t    payload_d, payload_q;
    logic        valid_d, valid_q;
    logic [15:0] bubble_count_d, bubble_count_q;
    logic        bubble;

    // flush and hazard together still make a single bubble
    assign bubble = bus.flush | bus.hazard;

    always_comb begin
        payload_d      = '0;
        valid_d        = 1'b0;
        bubble_count_d = bubble_count_q;
        if (bubble) begin
            if (bubble_count_q != 16'hFFFF) begin
                bubble_count_d = bubble_count_q + 16'd1;
            end
        end else begin
            payload_d.pc            = bus.pc_in;
            payload_d.val_rn        = bus.val_rn_in;
            payload_d.val_rm        = bus.val_rm_in;
            payload_d.shift_operand = bus.shift_operand_in;
            payload_d.signed_imm_24 = bus.signed_imm_24_in;
            payload_d.dest          = bus.dest_in;
            payload_d.exe_cmd       = bus.exe_cmd_in;
            payload_d.imm           = bus.imm_in;
            payload_d.mem_r_en      = bus.mem_r_en_in;
            payload_d.mem_w_en      = bus.mem_w_en_in;
            payload_d.wb_en         = bus.wb_en_in;
            payload_d.b             = bus.b_in;
            payload_d.s             = bus.s_in;
            payload_d.status_c      = bus.status_c_in;
            valid_d                 = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload_q      <= '0;
            valid_q        <= 1'b0;
            bubble_count_q <= '0;
        end else if (!bus.freeze) begin
            payload_q      <= payload_d;
            valid_q        <= valid_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.pc_out            = payload_q.pc;
    assign bus.val_rn_out        = payload_q.val_rn;
    assign bus.val_rm_out        = payload_q.val_rm;
    assign bus.shift_operand_out = payload_q.shift_operand;
    assign bus.signed_imm_24_out = payload_q.signed_imm_24;
    assign bus.dest_out          = payload_q.dest;
    assign bus.exe_cmd_out       = payload_q.exe_cmd;
    assign bus.imm_out           = payload_q.imm;
    assign bus.mem_r_en_out      = payload_q.mem_r_en;
    assign bus.mem_w_en_out      = payload_q.mem_w_en;
    assign bus.wb_en_out         = payload_q.wb_en;
    assign bus.b_out             = payload_q.b;
    assign bus.s_out             = payload_q.s;
    assign bus.status_c_out      = payload_q.status_c;
    assign bus.valid_out         = valid_q;
    assign bus.bubble_count      = bubble_count_q;

`ifdef FORWARDING_EN
    logic [3:0] src1_d, src1_q, src2_d, src2_q;

    always_comb begin
        src1_d = '0;
        src2_d = '0;
        if (!bubble) begin
            src1_d = bus.src1_in;
            src2_d = bus.src2_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src1_q <= '0;
            src2_q <= '0;
        end else if (!bus.freeze) begin
            src1_q <= src1_d;
            src2_q <= src2_d;
        end
    end

    assign bus.src1_out = src1_q;
    assign bus.src2_out = src2_q;
`else
    // Hazard unit resolves dependencies alone; source indices are not carried into EXE.
    logic unused_src;
    assign unused_src   = ^{bus.src1_in, bus.src2_in};
    assign bus.src1_out = '0;
    assign bus.src2_out = '0;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: the driver queues expected EXE-side state per cycle,
// a negedge monitor pops and compares. Reset checks are made directly, without a clock edge.
module tb_id_exe_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [11:0] shift_op;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  exe_cmd;
        logic        imm;
        logic        mem_r;
        logic        mem_w;
        logic        wb;
        logic        b;
        logic        s;
        logic        status_c;
    } stage_t;

    typedef struct packed {
        stage_t      data;
        logic        valid;
        logic [15:0] bc;
        logic        chk;
    } entry_t;

    localparam stage_t INST_A = '{pc: 32'h0000_0010, val_rm: 32'hDEAD_BEEF, shift_op: 12'h3A5,
                                  src1: 4'd3, src2: 4'd7, exe_cmd: 4'b0010, wb: 1'b1,
                                  default: '0};
    localparam stage_t INST_B = '{pc: 32'h1111_2222, val_rn: 32'h3333_4444,
                                  val_rm: 32'h5555_6666, shift_op: 12'hFFF, imm24: 24'hABCDEF,
                                  dest: 4'd9, src1: 4'd10, src2: 4'd11, exe_cmd: 4'b1111,
                                  imm: 1'b1, mem_r: 1'b1, mem_w: 1'b1, wb: 1'b1, b: 1'b1,
                                  s: 1'b1, status_c: 1'b1};
    localparam stage_t INST_C = '{pc: 32'h0000_0014, val_rn: 32'h0000_0100, shift_op: 12'h004,
                                  dest: 4'd5, src1: 4'd1, src2: 4'd2, exe_cmd: 4'b0100,
                                  imm: 1'b1, mem_r: 1'b1, wb: 1'b1, default: '0};
    localparam stage_t INST_FH = '{pc: 32'h0000_0040, dest: 4'd6, exe_cmd: 4'b0110,
                                   mem_w: 1'b1, b: 1'b1, wb: 1'b1, s: 1'b1, default: '0};
    localparam stage_t INST_D = '{pc: 32'h0000_0018, imm24: 24'h000ABC, exe_cmd: 4'b1001,
                                  b: 1'b1, s: 1'b1, status_c: 1'b1, src1: 4'd15,
                                  default: '0};
    localparam stage_t INST_F = '{pc: 32'h0000_0020, val_rn: 32'h0000_0005, dest: 4'd12,
                                  exe_cmd: 4'b0001, wb: 1'b1, default: '0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_exe_stage_reg_if bus ();

    id_exe_stage_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    entry_t      sb[$];
    entry_t      mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_bc   = '0;
    stage_t      exp_last = '0;
    logic        exp_valid_last = 1'b0;

    function automatic stage_t fwd_mask(input stage_t s);
        stage_t r;
        r = s;
`ifndef FORWARDING_EN
        r.src1 = '0;
        r.src2 = '0;
`endif
        return r;
    endfunction

    function automatic stage_t sample_out();
        stage_t r;
        r.pc       = bus.pc_out;
        r.val_rn   = bus.val_rn_out;
        r.val_rm   = bus.val_rm_out;
        r.shift_op = bus.shift_operand_out;
        r.imm24    = bus.signed_imm_24_out;
        r.dest     = bus.dest_out;
        r.src1     = bus.src1_out;
        r.src2     = bus.src2_out;
        r.exe_cmd  = bus.exe_cmd_out;
        r.imm      = bus.imm_out;
        r.mem_r    = bus.mem_r_en_out;
        r.mem_w    = bus.mem_w_en_out;
        r.wb       = bus.wb_en_out;
        r.b        = bus.b_out;
        r.s        = bus.s_out;
        r.status_c = bus.status_c_out;
        return r;
    endfunction

    task automatic drive(input stage_t s);
        bus.pc_in            = s.pc;
        bus.val_rn_in        = s.val_rn;
        bus.val_rm_in        = s.val_rm;
        bus.shift_operand_in = s.shift_op;
        bus.signed_imm_24_in = s.imm24;
        bus.dest_in          = s.dest;
        bus.src1_in          = s.src1;
        bus.src2_in          = s.src2;
        bus.exe_cmd_in       = s.exe_cmd;
        bus.imm_in           = s.imm;
        bus.mem_r_en_in      = s.mem_r;
        bus.mem_w_en_in      = s.mem_w;
        bus.wb_en_in         = s.wb;
        bus.b_in             = s.b;
        bus.s_in             = s.s;
        bus.status_c_in      = s.status_c;
    endtask

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_all(input string tag, input stage_t d, input logic v,
                             input logic [15:0] bc);
        check({tag, ".data"}, 160'(sample_out()), 160'(d));
        check({tag, ".valid"}, 160'(bus.valid_out), 160'(v));
        check({tag, ".bubble_count"}, 160'(bus.bubble_count), 160'(bc));
    endtask

    // Queue what EXE must show after the coming edge, then step to just past the next negedge.
    task automatic cycle(input stage_t d, input logic v, input logic chk);
        sb.push_back('{data: d, valid: v, bc: exp_bc, chk: chk});
        exp_last       = d;
        exp_valid_last = v;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input stage_t s);
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        bus.hazard = 1'b0;
        drive(s);
        cycle(fwd_mask(s), 1'b1, 1'b1);
    endtask

    task automatic do_bubble(input logic fl, input logic hz, input stage_t s, input logic chk);
        bus.freeze = 1'b0;
        bus.flush  = fl;
        bus.hazard = hz;
        drive(s);
        if (exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'd1;
        cycle('0, 1'b0, chk);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk) check_all("edge", mon_e.data, mon_e.valid, mon_e.bc);
        end
    end

    initial begin
        bus.freeze = 1'b0;
        bus.flush  = 1'b1;
        bus.hazard = 1'b1;
        drive(INST_B);
        #3;
        check_all("power_on_reset", '0, 1'b0, 16'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        do_load(INST_A);

        // Frozen with changing inputs and a pending flush: EXE must hold A.
        bus.freeze = 1'b1;
        bus.flush  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0] ? INST_C : INST_B);
            cycle(exp_last, exp_valid_last, 1'b1);
        end
        do_bubble(1'b1, 1'b0, INST_B, 1'b1);

        do_load(INST_C);
        do_bubble(1'b1, 1'b1, INST_FH, 1'b1);
        do_load(INST_D);
        do_bubble(1'b0, 1'b1, INST_B, 1'b1);
        do_load(INST_B);

        // Asynchronous reset in the middle of the low phase, inputs all nonzero.
        bus.flush  = 1'b1;
        bus.hazard = 1'b1;
        drive(INST_B);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset", '0, 1'b0, 16'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst    = 1'b0;
        exp_bc = '0;

        do_load(INST_C);
        for (int i = 0; i < 65540; i++) begin
            do_bubble(1'b0, 1'b1, INST_D, (i >= 65532) ? 1'b1 : 1'b0);
        end
        do_load(INST_F);
        do_bubble(1'b1, 1'b0, INST_F, 1'b1);
        do_load(INST_A);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", 160'(sb.size()), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
